// File: rtl/kicker_charge_ctrl.sv
// Kicker capacitor charge regulator and kick pulse sequencer.
// Hysteresis charge control, timed kicks, sticky ADC-loss and charge-timeout faults.
module kicker_charge_ctrl #(
  parameter int unsigned TICK_DIV       = 500,
  parameter int unsigned HYST           = 8,
  parameter int unsigned CHARGE_TIMEOUT = 50000,
  parameter int unsigned ADC_TIMEOUT    = 1000,
  parameter int unsigned COOLDOWN       = 100,
  parameter int unsigned MIN_KICK_V     = 64
) (
  input  logic       sysclk_i,
  input  logic       reset_i,
  input  logic       charge_enable_i,
  input  logic [7:0] target_voltage_i,
  input  logic       slave_ok_i,
  input  logic [7:0] result_i,
  input  logic       kick_request_i,
  input  logic [7:0] kick_strength_i,
  output logic       charge_out_o,
  output logic       kick_out_o,
  output logic       ready_o,
  output logic [1:0] fault_o
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TmrW  = $clog2(CHARGE_TIMEOUT + 1);
  localparam int unsigned WdW   = $clog2(ADC_TIMEOUT + 1);
  localparam int unsigned CntW  = ($clog2(COOLDOWN + 1) > 8) ? $clog2(COOLDOWN + 1) : 8;

  typedef enum logic [2:0] {
    StIdle,
    StCharge,
    StFull,
    StKick,
    StCooldown,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        fault_q, fault_d;
  logic              charge_q, kick_q, ready_q;

  logic              tick;
  logic              adc_trip;
  logic              kick_ok;
  logic [8:0]        recharge_th;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;

    tick     = (tick_q == TickW'(TICK_DIV - 1));
    adc_trip = !slave_ok_i && (wd_q == WdW'(ADC_TIMEOUT - 1));
    kick_ok  = kick_request_i && (kick_strength_i != 8'd0) &&
               ({1'b0, result_i} >= 9'(MIN_KICK_V));

    if (slave_ok_i) begin
      wd_d = '0;
    end else if (wd_q == WdW'(ADC_TIMEOUT)) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + WdW'(1);
    end

    // Threshold at 9 bits so small targets clamp to 0 instead of wrapping.
    if ({1'b0, target_voltage_i} > 9'(HYST)) begin
      recharge_th = {1'b0, target_voltage_i} - 9'(HYST);
    end else begin
      recharge_th = 9'd0;
    end

    unique case (state_q)
      StIdle: begin
        if (kick_ok) begin
          state_d = StKick;
          cnt_d   = CntW'(kick_strength_i);
        end else if (charge_enable_i && (fault_q == 2'b00)) begin
          state_d = StCharge;
          tmr_d   = '0;
        end
      end
      StCharge: begin
        if (!charge_enable_i) begin
          state_d = StIdle;
        end else if (result_i >= target_voltage_i) begin
          state_d = StFull;
        end else if (tick) begin
          if (tmr_q == TmrW'(CHARGE_TIMEOUT - 1)) begin
            state_d    = StFault;
            fault_d[1] = 1'b1;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
      end
      StFull: begin
        if (kick_ok) begin
          state_d = StKick;
          cnt_d   = CntW'(kick_strength_i);
        end else if (!charge_enable_i) begin
          state_d = StIdle;
        end else if ({1'b0, result_i} < recharge_th) begin
          state_d = StCharge;
          tmr_d   = '0;
        end
      end
      StKick: begin
        if (tick) begin
          if (cnt_q == CntW'(1)) begin
            state_d = StCooldown;
            cnt_d   = CntW'(COOLDOWN);
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StCooldown: begin
        if (tick) begin
          if (cnt_q == CntW'(1)) begin
            if (charge_enable_i && (fault_q == 2'b00)) begin
              state_d = StCharge;
              tmr_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StFault: begin
        if (!charge_enable_i) begin
          state_d = StIdle;
          fault_d = 2'b00;
          wd_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (adc_trip) begin
      state_d    = StFault;
      fault_d[0] = 1'b1;
    end

    // Prescaler restarts on KICK/COOLDOWN entry so pulse lengths are whole ticks.
    if ((state_d == StKick && state_q != StKick) ||
        (state_d == StCooldown && state_q != StCooldown) || tick) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + TickW'(1);
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      tmr_q    <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      fault_q  <= 2'b00;
      charge_q <= 1'b0;
      kick_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      tmr_q    <= tmr_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      charge_q <= (state_d == StCharge);
      kick_q   <= (state_d == StKick);
      ready_q  <= (state_d == StFull);
    end
  end

  assign charge_out_o = charge_q;
  assign kick_out_o   = kick_q;
  assign ready_o      = ready_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_kicker_charge_ctrl.sv
// Directed self-checking bench for kicker_charge_ctrl with short timing parameters.
module tb_kicker_charge_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] tgt;
  logic       sok;
  logic [7:0] res;
  logic       kreq;
  logic [7:0] kstr;
  logic       co;
  logic       ko;
  logic       rdy;
  logic [1:0] flt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kicker_charge_ctrl #(
    .TICK_DIV      (4),
    .HYST          (8),
    .CHARGE_TIMEOUT(10),
    .ADC_TIMEOUT   (8),
    .COOLDOWN      (3),
    .MIN_KICK_V    (64)
  ) dut (
    .sysclk_i        (clk),
    .reset_i         (rst),
    .charge_enable_i (ce),
    .target_voltage_i(tgt),
    .slave_ok_i      (sok),
    .result_i        (res),
    .kick_request_i  (kreq),
    .kick_strength_i (kstr),
    .charge_out_o    (co),
    .kick_out_o      (ko),
    .ready_o         (rdy),
    .fault_o         (flt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_kick(input logic [7:0] s);
    kreq = 1'b1;
    kstr = s;
    step();
    kreq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; tgt = 8'd200; sok = 1'b1; res = 8'd100; kreq = 1'b0; kstr = 8'd0;
    step(); step();
    n_cmp++;
    if ({co, ko, rdy, flt} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000", {co, ko, rdy, flt});
    end
  endtask

  task automatic test_regulation();
    rst = 1'b0;
    step();
    n_cmp++;
    if (co !== 1'b1 || rdy !== 1'b0) begin
      n_bad++; $display("FAIL reg_charge_start: co=%b rdy=%b want 1 0", co, rdy);
    end
    res = 8'd200; step();
    n_cmp++;
    if (co !== 1'b0 || rdy !== 1'b1) begin
      n_bad++; $display("FAIL reg_full: co=%b rdy=%b want 0 1", co, rdy);
    end
    res = 8'd193; step();
    res = 8'd192; step();
    n_cmp++;
    if (co !== 1'b0 || rdy !== 1'b1) begin
      n_bad++; $display("FAIL reg_hyst_hold: co=%b rdy=%b want 0 1", co, rdy);
    end
    res = 8'd191; step();
    n_cmp++;
    if (co !== 1'b1 || rdy !== 1'b0) begin
      n_bad++; $display("FAIL reg_recharge: co=%b rdy=%b want 1 0", co, rdy);
    end
    res = 8'd200; step();
  endtask

  task automatic test_kick();
    logic ok;
    pulse_kick(8'd5);
    n_cmp++;
    if (ko !== 1'b1 || co !== 1'b0) begin
      n_bad++; $display("FAIL kick_start: ko=%b co=%b want 1 0", ko, co);
    end
    ok = 1'b1;
    for (int i = 2; i <= 20; i++) begin
      if (i == 5) ce = 1'b0;
      if (i == 10) ce = 1'b1;
      step();
      if (ko !== 1'b1 || co !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL kick_width: high_run_ok=%b want 1", ok);
    end
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ko !== 1'b0 || co !== 1'b0 || rdy !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL kick_cooldown: quiet_ok=%b want 1", ok);
    end
    step();
    n_cmp++;
    if (co !== 1'b1 || ko !== 1'b0) begin
      n_bad++; $display("FAIL kick_recharge: co=%b ko=%b want 1 0", co, ko);
    end
    step();
  endtask

  task automatic test_rejection();
    int highs;
    ce = 1'b0; step();
    n_cmp++;
    if ({co, ko, rdy} !== 3'b000) begin
      n_bad++; $display("FAIL rej_idle: got %b want 000", {co, ko, rdy});
    end
    res = 8'd50; pulse_kick(8'd5); step();
    n_cmp++;
    if (ko !== 1'b0) begin
      n_bad++; $display("FAIL rej_low_v50: ko=%b want 0", ko);
    end
    res = 8'd63; pulse_kick(8'd5);
    n_cmp++;
    if (ko !== 1'b0) begin
      n_bad++; $display("FAIL rej_low_v63: ko=%b want 0", ko);
    end
    res = 8'd200; pulse_kick(8'd0);
    n_cmp++;
    if (ko !== 1'b0) begin
      n_bad++; $display("FAIL rej_zero_strength: ko=%b want 0", ko);
    end
    res = 8'd64; pulse_kick(8'd2);
    n_cmp++;
    if (ko !== 1'b1) begin
      n_bad++; $display("FAIL rej_min_v_accept: ko=%b want 1", ko);
    end
    highs = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) begin kreq = 1'b1; kstr = 8'd5; end
      if (i == 2) kreq = 1'b0;
      step();
      if (ko === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 8) begin
      n_bad++; $display("FAIL rej_during_kick: high_cycles=%0d want 8", highs);
    end
  endtask

  task automatic test_charge_timeout();
    int n;
    ce = 1'b1; tgt = 8'd200; res = 8'd100; step();
    n_cmp++;
    if (co !== 1'b1) begin
      n_bad++; $display("FAIL to_charge: co=%b want 1", co);
    end
    n = 0;
    while (flt === 2'b00 && n < 60) begin
      step(); n++;
    end
    n_cmp++;
    if (flt !== 2'b10 || co !== 1'b0) begin
      n_bad++; $display("FAIL to_fault: flt=%b co=%b want 10 0", flt, co);
    end
    n_cmp++;
    if (n < 37 || n > 40) begin
      n_bad++; $display("FAIL to_latency: cycles=%0d want 37..40", n);
    end
    res = 8'd200; pulse_kick(8'd5);
    n_cmp++;
    if (ko !== 1'b0 || flt !== 2'b10) begin
      n_bad++; $display("FAIL to_kick_ignored: ko=%b flt=%b want 0 10", ko, flt);
    end
    ce = 1'b0; step();
    n_cmp++;
    if (flt !== 2'b00 || {co, ko, rdy} !== 3'b000) begin
      n_bad++; $display("FAIL to_clear: flt=%b outs=%b want 00 000", flt, {co, ko, rdy});
    end
    ce = 1'b1; step();
    n_cmp++;
    if (co !== 1'b1) begin
      n_bad++; $display("FAIL to_restart: co=%b want 1", co);
    end
    step();
  endtask

  task automatic test_adc_loss();
    sok = 1'b0;
    for (int i = 0; i < 7; i++) step();
    sok = 1'b1; step();
    n_cmp++;
    if (flt !== 2'b00 || rdy !== 1'b1) begin
      n_bad++; $display("FAIL adc_short_loss: flt=%b rdy=%b want 00 1", flt, rdy);
    end
    pulse_kick(8'd5); step(); step();
    sok = 1'b0;
    for (int i = 0; i < 7; i++) step();
    n_cmp++;
    if (ko !== 1'b1 || flt !== 2'b00) begin
      n_bad++; $display("FAIL adc_pre_trip: ko=%b flt=%b want 1 00", ko, flt);
    end
    step();
    n_cmp++;
    if (ko !== 1'b0 || co !== 1'b0 || flt !== 2'b01) begin
      n_bad++; $display("FAIL adc_trip_kick: ko=%b co=%b flt=%b want 0 0 01", ko, co, flt);
    end
    sok = 1'b1; ce = 1'b0; step();
    n_cmp++;
    if (flt !== 2'b00) begin
      n_bad++; $display("FAIL adc_clear: flt=%b want 00", flt);
    end
  endtask

  task automatic test_reset_mid_kick();
    ce = 1'b1; res = 8'd200; step(); step();
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++; $display("FAIL rmk_full: rdy=%b want 1", rdy);
    end
    pulse_kick(8'd5);
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (ko !== 1'b1) begin
      n_bad++; $display("FAIL rmk_kick_cycle6: ko=%b want 1", ko);
    end
    rst = 1'b1; step();
    n_cmp++;
    if ({co, ko, rdy, flt} !== 5'b00000) begin
      n_bad++; $display("FAIL rmk_reset: got %b want 00000", {co, ko, rdy, flt});
    end
    rst = 1'b0; res = 8'd100; step();
    n_cmp++;
    if (co !== 1'b1 || ko !== 1'b0) begin
      n_bad++; $display("FAIL rmk_recharge: co=%b ko=%b want 1 0", co, ko);
    end
    step();
    n_cmp++;
    if (co !== 1'b1 || rdy !== 1'b0) begin
      n_bad++; $display("FAIL rmk_charge_hold: co=%b rdy=%b want 1 0", co, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_regulation();
    test_kick();
    test_rejection();
    test_charge_timeout();
    test_adc_loss();
    test_reset_mid_kick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kicker_charge_ctrl.md
Name: kicker_charge_ctrl

Overview:
Consumes the 8-bit kicker capacitor voltage and slave_ok status produced by the kicker I2C ADC reader. Drives the kicker charger enable with hysteresis regulation and fires timed kick pulses. Enforces charge-timeout and ADC-loss fault shutdown.
Sits between the kicker I2C reader and the charger and kick driver pins in the robot FPGA.

Parameters:
TICK_DIV, 500, sysclk cycles per timing tick.
HYST, 8, LSBs below target at which recharge restarts.
CHARGE_TIMEOUT, 50000, ticks allowed in CHARGE before fault.
ADC_TIMEOUT, 1000, consecutive sysclk cycles with slave_ok=0 before fault.
COOLDOWN, 100, ticks after a kick before charging may resume.
MIN_KICK_V, 64, minimum result value for a kick to be accepted.

Ports:
sysclk  in  1  system clock; everything is on posedge.
reset  in  1  synchronous, active-high reset.
charge_enable  in  1  host permits charging; a low level clears faults.
target_voltage  in  8  regulation setpoint, in ADC result units.
slave_ok  in  1  ADC acknowledged its last transaction.
result  in  8  latest capacitor voltage sample.
kick_request  in  1  one-cycle kick command.
kick_strength  in  8  kick pulse length in ticks; 0 means no kick.
charge_out  out  1  charger enable (registered).
kick_out  out  1  kick solenoid drive (registered).
ready  out  1  high when in FULL.
fault  out  2  [0] ADC lost, [1] charge timeout; both sticky.

Behaviour:
- Reset: state=IDLE. charge_out, kick_out, ready and fault are all 0. Tick prescaler, charge timer, kick/cooldown counter and ADC watchdog are all cleared.
- Reset asserted mid-operation takes effect on the same edge. A kick in progress is truncated.
- All outputs are registered. A state decision made from inputs at edge N is visible after edge N.
- Tick prescaler: counts 0..TICK_DIV-1 and pulses tick on wrap. It free-runs, except that it is reloaded to 0 on entry to KICK and on entry to COOLDOWN, so pulse lengths are exact.
- ADC watchdog: increments while slave_ok=0 and clears when slave_ok=1. Reaching ADC_TIMEOUT sets fault[0] and forces FAULT from any state, including KICK.
- State IDLE: all outputs 0.
  - Go to CHARGE when charge_enable=1 and fault=0; the charge timer clears.
- State CHARGE: charge_out=1.
  - result >= target_voltage -> FULL.
  - charge_enable=0 -> IDLE.
  - Charge timer (counts ticks) reaches CHARGE_TIMEOUT -> fault[1]=1 and go to FAULT.
- State FULL: charge_out=0, ready=1.
  - Recharge threshold is computed at 9-bit width: th = target-HYST if target > HYST, else 0.
  - result < th -> CHARGE, with the timer cleared.
  - charge_enable=0 -> IDLE.
  - target_voltage=0 stays FULL permanently.
- Kick acceptance: only in IDLE or FULL, and only when kick_request=1, kick_strength != 0 and result >= MIN_KICK_V.
  - kick_strength is latched on acceptance.
  - Kick takes priority over recharge and over charge_enable=0 on the same cycle.
  - Requests in any other state, or failing any condition, are dropped and never queued.
- State KICK: kick_out=1 and charge_out=0.
  - kick_out stays high exactly latched_strength*TICK_DIV cycles, then the block enters COOLDOWN.
  - charge_enable changes do not truncate the kick.
- State COOLDOWN: all outputs 0 for exactly COOLDOWN*TICK_DIV cycles.
  - Then CHARGE if charge_enable=1 and fault=0, else IDLE.
- State FAULT: charge_out=0, kick_out=0, ready=0.
  - Leave only after charge_enable is sampled 0: go to IDLE, fault=0, watchdog cleared.
  - If the ADC is still lost, the watchdog re-faults after ADC_TIMEOUT cycles.
- Invariant: charge_out and kick_out are never both 1 on any cycle.
- Simultaneous events in CHARGE: a timeout and result >= target on the same cycle -> FULL, with no fault. An ADC fault outranks everything except reset.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, CHARGE_TIMEOUT=10, ADC_TIMEOUT=8, HYST=8, COOLDOWN=3, MIN_KICK_V=64, slave_ok=1 unless stated.
1. Regulation: release reset, charge_enable=1, target=200, result=100 -> charge_out=1 one cycle later. result=200 -> charge_out=0, ready=1 next cycle. result=193 -> stays FULL. result=191 -> charge_out=1.
2. Kick: in FULL with result=200, kick_request pulse with strength=5 -> kick_out=1 starting the next cycle for exactly 20 cycles, charge_out=0 throughout. Then 12 cycles with both outputs 0, then charge_out=1.
3. Rejection: in IDLE with result=50, kick with strength=5 -> kick_out stays 0. With result=200 and strength=0 -> kick_out stays 0. A second request during KICK -> no pulse extension and no second kick.
4. Charge timeout: target=200 with result stuck at 100 -> fault=2'b10 and charge_out=0 after 10 ticks. A kick request while faulted is ignored. Drop charge_enable for 1 cycle -> fault=0, state IDLE.
5. ADC loss: slave_ok=0 for 7 cycles then 1 -> no fault. slave_ok=0 for 8 cycles during KICK -> kick_out=0 and fault=2'b01.
6. Reset mid-kick: assert reset at kick cycle 6 -> all outputs 0 after that edge. Release with charge_enable=1 -> state returns to CHARGE.
